uart_tx_sb_ctrl: RTL and testbench
==================================

Name: uart_tx_sb_ctrl

Overview:
- Memory-mapped UART transmitter on the system bus; the transmit counterpart of the UART receive controller.
- Holds configuration registers (baudrate, parity enable, stop bits), accepts a byte via bus write and serialises it on tx_o.
- Bit timing comes from a phase-accumulator baud generator, so any legal baudrate works without a hardware divider.

Parameters:
- CLK_FREQ_HZ, 10_000_000, system clock frequency, used by the baud accumulator.
- DEF_BAUD, 9600, baudrate value after reset and after soft reset.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous, active-low reset
- addr_i  in  32  bus byte address
- req_i  in  1  bus request
- write_data_i  in  32  bus write data
- write_enable_i  in  1  1 = write, 0 = read
- read_data_o  out  32  combinational read data
- busy_o  out  1  frame in progress
- tx_o  out  1  serial line, idle high

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is asynchronous and active-low.
- Reset values:
  - tx_o=1, busy_o=0, state=IDLE, accumulator=0.
  - baudrate=DEF_BAUD, parity_en=1, stopbit=1, data_reg=0.
  - read_data_o=0 whenever there is no read request.
- Register map (word addresses):
  - 0x00 data: RW, bits [7:0].
  - 0x08 busy: RO.
  - 0x0C baudrate: RW, 32 bit.
  - 0x10 parity_en: RW, bit 0.
  - 0x14 stopbit: RW, bit 0. 0 = one stop bit, 1 = two stop bits.
  - 0x24 soft reset: WO.
- Reads:
  - Combinational, active when req_i & !write_enable_i.
  - Unmapped addresses, and reads of 0x24, return 0.
- Writes:
  - A write is req_i & write_enable_i, sampled on the clock edge.
  - While busy_o=1, writes to 0x00, 0x0C, 0x10 and 0x14 are ignored.
  - A baudrate write of 0, or of a value greater than CLK_FREQ_HZ/2, is ignored and the register keeps its old value.
- Frame start:
  - Trigger: write to 0x00 with busy_o=0 at edge N.
  - At edge N: data_reg latches write_data_i[7:0]; state becomes START.
  - From cycle N+1: busy_o=1, tx_o=0, accumulator cleared to 0.
- Baud tick:
  - Each cycle, sum = acc + baudrate.
  - If sum >= CLK_FREQ_HZ: tick=1 and acc <= sum - CLK_FREQ_HZ. Otherwise acc <= sum.
  - The accumulator is wide enough for 2*CLK_FREQ_HZ.
  - Each bit lasts until its tick, i.e. CLK_FREQ_HZ/baudrate cycles for exact ratios.
- FSM:
  - IDLE: tx_o=1.
  - START: tx_o=0. On tick go to DATA, with bit index 0.
  - DATA: tx_o=data_reg[idx], LSB first. On tick, idx++. After idx 7, go to PARITY if parity_en=1, else to STOP.
  - PARITY: tx_o=^data_reg (even parity). On tick go to STOP.
  - STOP: tx_o=1. On tick, if this was the last stop bit go to IDLE, otherwise stay in STOP for a second bit.
- End of frame: busy_o falls the cycle after the final stop tick. A new byte may then be written immediately, giving back-to-back frames.
- Config latching: parity_en and stopbit are sampled at frame start. Writes to them mid-frame are ignored anyway.
- Soft reset: write to 0x24, any data, any busy state.
  - Next edge: FSM returns to IDLE, tx_o=1, busy_o=0, accumulator=0.
  - Config and data_reg return to their reset values.
  - Mid-frame this aborts the frame; the line is left high.
- Async reset mid-frame: tx_o=1 immediately, with no glitch low.

Decomposition:
- Package uart_pkg:
  - tx_state_t enum: IDLE, START, DATA, PARITY, STOP.
  - Address constants UART_DATA_ADDR=0x00, UART_BUSY_ADDR=0x08, UART_BAUD_ADDR=0x0C, UART_PARITY_ADDR=0x10, UART_STOP_ADDR=0x14, UART_RST_ADDR=0x24.
  - These are shared with the receive controller.
- Sub-module uart_tx:
  - Contains the FSM, baud accumulator and shift logic.
  - Inputs: baudrate, parity_en, stopbit, data, start.
  - Outputs: tx_o, busy_o.
  - The top level holds the register file and bus decode.

Test Plan:
All scenarios use CLK_FREQ_HZ=10_000_000.
- Default check: after reset, read 0x0C -> 9600; read 0x10 -> 1; read 0x14 -> 1; read 0x08 -> 0; tx_o=1.
- Baseline frame: write 0x0C=1_000_000 (10 cycles/bit), then write 0x00=0xA5.
  - tx_o = 0, 1,0,1,0,0,1,0,1, 0 (parity), 1, 1, each 10 cycles.
  - busy_o stays high exactly 120 cycles.
- Short frame: parity_en=0, stopbit=0, data 0x01 -> frame is 0,1,0×7,1 = 100 cycles; busy_o then falls.
- Busy guard: write 0x00=0x3C during the 0xA5 frame, then write 0x0C=5 -> transmitted byte stays 0xA5, baudrate stays 1_000_000, no second frame starts.
- Soft reset mid-frame: write 0x24 at cycle 40 of a frame -> tx_o=1 and busy_o=0 next cycle; read 0x0C -> 9600.
- Back-to-back and illegal baud: write 0x0C=0 -> ignored; two consecutive frames 0xFF then 0x00 with no idle gap beyond one cycle; parity bits 0 then 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states and the bus register map
// (used by both the transmit and the receive controllers).
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic [31:0] UART_DATA_ADDR   = 32'h0000_0000;
  localparam logic [31:0] UART_BUSY_ADDR   = 32'h0000_0008;
  localparam logic [31:0] UART_BAUD_ADDR   = 32'h0000_000C;
  localparam logic [31:0] UART_PARITY_ADDR = 32'h0000_0010;
  localparam logic [31:0] UART_STOP_ADDR   = 32'h0000_0014;
  localparam logic [31:0] UART_RST_ADDR    = 32'h0000_0024;

endpackage

// File: rtl/uart_tx.sv
// UART transmit engine: phase-accumulator baud tick, frame FSM and a registered line driver.
//   state  | meaning
//   IDLE   | line high, waiting for start_i
//   START  | start bit (low)
//   DATA   | data bits, LSB first, idx_q selects the bit
//   PARITY | even parity of the data byte
//   STOP   | stop bit(s), second one only when two were latched at frame start
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 10_000_000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        soft_rst_i,
  input  logic        start_i,
  input  logic [7:0]  data_i,
  input  logic [31:0] baudrate_i,
  input  logic        parity_en_i,
  input  logic        stopbit_i,
  output logic        tx_o,
  output logic        busy_o
);

  localparam int ACC_W = $clog2(2 * CLK_FREQ_HZ + 1);
  localparam logic [ACC_W-1:0] CLK_FREQ = ACC_W'(CLK_FREQ_HZ);

  tx_state_t        state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [ACC_W-1:0] acc_q, acc_d, sum;
  logic             par_q, par_d;
  logic             stop2_q, stop2_d;
  logic             stop_second_q, stop_second_d;
  logic             tx_d;
  logic             tick;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      acc_q         <= '0;
      par_q         <= 1'b1;
      stop2_q       <= 1'b1;
      stop_second_q <= 1'b0;
      tx_o          <= 1'b1;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      acc_q         <= acc_d;
      par_q         <= par_d;
      stop2_q       <= stop2_d;
      stop_second_q <= stop_second_d;
      tx_o          <= tx_d;
    end
  end

  // Baudrate never exceeds CLK_FREQ/2 and acc stays below CLK_FREQ, so the sum cannot wrap.
  assign sum  = acc_q + ACC_W'(baudrate_i);
  assign tick = (sum >= CLK_FREQ);

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    acc_d         = acc_q;
    par_d         = par_q;
    stop2_d       = stop2_q;
    stop_second_d = stop_second_q;
    tx_d          = 1'b1;

    if (state_q != IDLE) begin
      acc_d = tick ? (sum - CLK_FREQ) : sum;
    end

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d       = START;
          acc_d         = '0;
          par_d         = parity_en_i;
          stop2_d       = stopbit_i;
          stop_second_d = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (tick) begin
          if (idx_q == 3'd7) begin
            state_d = par_q ? PARITY : STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (tick) state_d = STOP;
      end
      STOP: begin
        if (tick) begin
          if (stop2_q && !stop_second_q) begin
            stop_second_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (soft_rst_i) begin
      state_d       = IDLE;
      acc_d         = '0;
      idx_d         = '0;
      stop_second_d = 1'b0;
    end

    // Line level is registered from the next state so tx_o never glitches.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = data_i[idx_d];
      PARITY:  tx_d = ^data_i;
      default: tx_d = 1'b1;
    endcase
  end

  assign busy_o = (state_q != IDLE);

endmodule

// File: rtl/uart_tx_sb_ctrl.sv
// System-bus UART transmitter: register file and address decode around the uart_tx engine.
module uart_tx_sb_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 10_000_000,
  parameter logic [31:0] DEF_BAUD    = 32'd9600
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] addr_i,
  input  logic        req_i,
  input  logic [31:0] write_data_i,
  input  logic        write_enable_i,
  output logic [31:0] read_data_o,
  output logic        busy_o,
  output logic        tx_o
);

  localparam logic [31:0] BAUD_MAX = 32'(CLK_FREQ_HZ / 2);

  logic [31:0] baud_q;
  logic        par_q;
  logic        stop_q;
  logic [7:0]  data_q;
  logic        wr, rd, start, soft_rst;

  assign wr       = req_i & write_enable_i;
  assign rd       = req_i & ~write_enable_i;
  assign start    = wr && (addr_i == UART_DATA_ADDR) && !busy_o;
  assign soft_rst = wr && (addr_i == UART_RST_ADDR);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      baud_q <= DEF_BAUD;
      par_q  <= 1'b1;
      stop_q <= 1'b1;
      data_q <= '0;
    end else if (soft_rst) begin
      baud_q <= DEF_BAUD;
      par_q  <= 1'b1;
      stop_q <= 1'b1;
      data_q <= '0;
    end else if (wr && !busy_o) begin
      case (addr_i)
        UART_DATA_ADDR:   data_q <= write_data_i[7:0];
        UART_BAUD_ADDR: begin
          // Zero or above Nyquist of the clock would break the accumulator; keep the old rate.
          if ((write_data_i != '0) && (write_data_i <= BAUD_MAX)) baud_q <= write_data_i;
        end
        UART_PARITY_ADDR: par_q  <= write_data_i[0];
        UART_STOP_ADDR:   stop_q <= write_data_i[0];
        default: ;
      endcase
    end
  end

  always_comb begin
    read_data_o = '0;
    if (rd) begin
      case (addr_i)
        UART_DATA_ADDR:   read_data_o = {24'd0, data_q};
        UART_BUSY_ADDR:   read_data_o = {31'd0, busy_o};
        UART_BAUD_ADDR:   read_data_o = baud_q;
        UART_PARITY_ADDR: read_data_o = {31'd0, par_q};
        UART_STOP_ADDR:   read_data_o = {31'd0, stop_q};
        default:          read_data_o = '0;
      endcase
    end
  end

  uart_tx #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ)
  ) u_tx (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .soft_rst_i  (soft_rst),
    .start_i     (start),
    .data_i      (data_q),
    .baudrate_i  (baud_q),
    .parity_en_i (par_q),
    .stopbit_i   (stop_q),
    .tx_o        (tx_o),
    .busy_o      (busy_o)
  );

endmodule

// File: tb/tb_uart_tx_sb_ctrl.sv
// Bench for uart_tx_sb_ctrl: directed and random frames against a bit-timing model.
module tb_uart_tx_sb_ctrl;
  import uart_pkg::*;

  localparam longint CLK = 10_000_000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr;
  logic        req;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] rdata;
  logic        busy;
  logic        tx;

  int checks   = 0;
  int failures = 0;

  uart_tx_sb_ctrl #(
    .CLK_FREQ_HZ(10_000_000),
    .DEF_BAUD   (32'd9600)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_n),
    .addr_i        (addr),
    .req_i         (req),
    .write_data_i  (wdata),
    .write_enable_i(we),
    .read_data_o   (rdata),
    .busy_o        (busy),
    .tx_o          (tx)
  );

  always #5 clk = ~clk;

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1'b1; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0;
  endtask

  task automatic check_read(input logic [31:0] a, input logic [31:0] exp, input string tag);
    addr = a; we = 1'b0; req = 1'b1;
    #1;
    chk(rdata, exp, tag);
    req = 1'b0;
    @(posedge clk); #1;
  endtask

  // Sample s (s=0 right after the start edge) carries frame bit floor(s*baud/CLK);
  // once that index reaches the frame length the line is idle.
  task automatic run_frame(input logic [7:0] d, input longint baud, input bit par, input bit st2,
                           input int inj_s, input logic [31:0] inj_a, input logic [31:0] inj_d,
                           input int inj2_s, input logic [31:0] inj2_a, input logic [31:0] inj2_d,
                           input string tag, output int busy_cnt);
    bit     q[$];
    longint nbits, end_s, k;
    bit     aborted, etx, ebusy;
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) q.push_back(d[i]);
    if (par) q.push_back(bit'($countones(d) % 2));
    q.push_back(1'b1);
    if (st2) q.push_back(1'b1);
    nbits   = q.size();
    end_s   = (nbits * CLK + baud - 1) / baud;
    aborted = (inj_s >= 0) && (inj_a == UART_RST_ADDR);
    if (aborted) end_s = inj_s + 1;
    busy_cnt = 0;
    bus_write(UART_DATA_ADDR, {24'd0, d});
    for (longint s = 0; s <= end_s; s++) begin
      k = s * baud / CLK;
      if (aborted && s > inj_s) begin
        etx = 1'b1; ebusy = 1'b0;
      end else if (k < nbits) begin
        etx = q[k]; ebusy = 1'b1;
      end else begin
        etx = 1'b1; ebusy = 1'b0;
      end
      chk({31'd0, tx}, {31'd0, etx}, $sformatf("%s tx s=%0d", tag, s));
      chk({31'd0, busy}, {31'd0, ebusy}, $sformatf("%s busy s=%0d", tag, s));
      if (busy) busy_cnt++;
      if (s == end_s) break;
      if (s == inj_s) begin
        addr = inj_a; wdata = inj_d; we = 1'b1; req = 1'b1;
      end else if (s == inj2_s) begin
        addr = inj2_a; wdata = inj2_d; we = 1'b1; req = 1'b1;
      end
      @(posedge clk); #1;
      req = 1'b0; we = 1'b0;
    end
  endtask

  initial begin
    int          bc;
    logic [7:0]  rd_byte;
    logic [31:0] rbaud;
    bit          rpar, rst2;

    rst_n = 1'b0; addr = '0; req = 1'b0; wdata = '0; we = 1'b0;
    #23 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset state and register map defaults.
    chk({31'd0, tx},   32'd1, "reset tx");
    chk({31'd0, busy}, 32'd0, "reset busy");
    chk(rdata,         32'd0, "no-req rdata");
    check_read(UART_BAUD_ADDR,   32'd9600, "reset baud");
    check_read(UART_PARITY_ADDR, 32'd1,    "reset parity");
    check_read(UART_STOP_ADDR,   32'd1,    "reset stop");
    check_read(UART_BUSY_ADDR,   32'd0,    "reset busy reg");
    check_read(UART_DATA_ADDR,   32'd0,    "reset data");
    check_read(UART_RST_ADDR,    32'd0,    "read soft-rst addr");
    check_read(32'h0000_0004,    32'd0,    "read unmapped 0x04");

    // Baseline 0xA5 frame at 10 cycles/bit.
    bus_write(UART_BAUD_ADDR, 32'd1_000_000);
    check_read(UART_BAUD_ADDR, 32'd1_000_000, "baud 1M");
    run_frame(8'hA5, 1_000_000, 1, 1, -1, '0, '0, -1, '0, '0, "base", bc);
    chk(bc, 32'd120, "base busy cycles");

    // Busy guard: data and baud writes mid-frame are dropped.
    run_frame(8'hA5, 1_000_000, 1, 1, 20, UART_DATA_ADDR, 32'h3C, 50, UART_BAUD_ADDR, 32'd5,
              "guard", bc);
    check_read(UART_BAUD_ADDR, 32'd1_000_000, "guard baud kept");
    check_read(UART_DATA_ADDR, 32'h0000_00A5, "guard data kept");
    for (int i = 0; i < 20; i++) begin
      chk({31'd0, busy}, 32'd0, "guard no second frame");
      @(posedge clk); #1;
    end

    // Short frame: no parity, one stop bit.
    bus_write(UART_PARITY_ADDR, 32'd0);
    bus_write(UART_STOP_ADDR, 32'd0);
    run_frame(8'h01, 1_000_000, 0, 0, -1, '0, '0, -1, '0, '0, "short", bc);
    chk(bc, 32'd100, "short busy cycles");

    // Baudrate legality boundaries.
    bus_write(UART_BAUD_ADDR, 32'd0);
    check_read(UART_BAUD_ADDR, 32'd1_000_000, "baud 0 ignored");
    bus_write(UART_BAUD_ADDR, 32'd5_000_001);
    check_read(UART_BAUD_ADDR, 32'd1_000_000, "baud >clk/2 ignored");
    bus_write(UART_BAUD_ADDR, 32'd5_000_000);
    check_read(UART_BAUD_ADDR, 32'd5_000_000, "baud clk/2 accepted");
    bus_write(UART_BAUD_ADDR, 32'd1_000_000);

    // Back-to-back frames with default framing.
    bus_write(UART_PARITY_ADDR, 32'd1);
    bus_write(UART_STOP_ADDR, 32'd1);
    run_frame(8'hFF, 1_000_000, 1, 1, -1, '0, '0, -1, '0, '0, "b2b ff", bc);
    run_frame(8'h00, 1_000_000, 1, 1, -1, '0, '0, -1, '0, '0, "b2b 00", bc);
    chk(bc, 32'd120, "b2b second busy cycles");

    // Soft reset at cycle 40 of a frame.
    @(posedge clk); #1;
    run_frame(8'hA5, 1_000_000, 1, 1, 39, UART_RST_ADDR, 32'hDEAD_BEEF, -1, '0, '0, "srst", bc);
    check_read(UART_BAUD_ADDR,   32'd9600, "srst baud");
    check_read(UART_PARITY_ADDR, 32'd1,    "srst parity");
    check_read(UART_STOP_ADDR,   32'd1,    "srst stop");
    check_read(UART_DATA_ADDR,   32'd0,    "srst data");

    // Random configurations, including non-integer baud ratios.
    for (int it = 0; it < 6; it++) begin
      rbaud   = $urandom_range(5_000_000, 250_000);
      rd_byte = 8'($urandom);
      rpar    = 1'($urandom);
      rst2    = 1'($urandom);
      bus_write(UART_BAUD_ADDR, rbaud);
      bus_write(UART_BAUD_ADDR, $urandom_range(32'hFFFF_FFFF, 32'd5_000_001));
      check_read(UART_BAUD_ADDR, rbaud, $sformatf("rand%0d baud", it));
      bus_write(UART_PARITY_ADDR, {31'd0, rpar});
      bus_write(UART_STOP_ADDR, {31'd0, rst2});
      check_read(UART_PARITY_ADDR, {31'd0, rpar}, $sformatf("rand%0d parity", it));
      run_frame(rd_byte, longint'(rbaud), rpar, rst2, -1, '0, '0, -1, '0, '0,
                $sformatf("rand%0d", it), bc);
    end

    // Async reset mid-frame forces the line high at once.
    bus_write(UART_BAUD_ADDR, 32'd1_000_000);
    bus_write(UART_DATA_ADDR, 32'h00);
    check_read(UART_BUSY_ADDR, 32'd1, "busy reg during frame");
    chk({31'd0, tx}, 32'd0, "pre-arst tx low");
    #2 rst_n = 1'b0;
    #1;
    chk({31'd0, tx},   32'd1, "arst tx high");
    chk({31'd0, busy}, 32'd0, "arst busy low");
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check_read(UART_BAUD_ADDR, 32'd9600, "arst baud");
    chk({31'd0, tx}, 32'd1, "arst tx idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
